// File: rtl/wb_lsu_master_pkg.sv
// Shared types and constants for the LSU Wishbone initiator.
// Holds size/status codes, sel encodings and helper functions.
package wb_lsu_master_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_TAG  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_TAG_FAULT = 2'd1,
    ST_MISALIGN  = 2'd2,
    ST_TIMEOUT   = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_CHECK,
    S_RESP
  } state_e;

  typedef struct packed {
    logic  we;
    size_e size;
    logic  uns;
    logic  chk;
  } req_t;

  localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
  localparam logic [3:0] WB_SEL_HALF = 4'b0011;
  localparam logic [3:0] WB_SEL_WORD = 4'b1111;
  localparam logic [3:0] WB_SEL_TAG  = 4'b0101;

  localparam int PTR_TAG_LSB = 26;
  localparam int PTR_TAG_MSB = 29;

  function automatic logic [3:0] sel_for(
    input size_e sz
  );
    case (sz)
      SZ_BYTE: sel_for = WB_SEL_BYTE;
      SZ_HALF: sel_for = WB_SEL_HALF;
      SZ_WORD: sel_for = WB_SEL_WORD;
      default: sel_for = WB_SEL_TAG;
    endcase
  endfunction

  // Tag accesses address a granule, so
  // they carry no alignment constraint.
  function automatic logic misaligned(
    input size_e      sz,
    input logic [1:0] a
  );
    misaligned =
      (sz == SZ_HALF && a[0]) ||
      (sz == SZ_WORD && a != 2'b00);
  endfunction

  function automatic logic [3:0] ptr_tag(
    input logic [31:0] p
  );
    ptr_tag = p[PTR_TAG_MSB:PTR_TAG_LSB];
  endfunction

endpackage

// File: rtl/wb_lsu_load_align.sv
// Load data select and extension.
// In: size, unsigned, we, raw bus data. Out: extended data.
module wb_lsu_load_align
  import wb_lsu_master_pkg::*;
#(
  parameter int DW = 32,
  parameter int TW = 4
) (
  input  size_e           size,
  input  logic            uns,
  input  logic            we,
  input  logic [DW-1:0]   raw,
  output logic [DW-1:0]   data
);

  always_comb begin
    data = '0;
    if (!we) begin
      unique case (size)
        SZ_BYTE: data = {{(DW-8){~uns & raw[7]}},
                         raw[7:0]};
        SZ_HALF: data = {{(DW-16){~uns & raw[15]}},
                         raw[15:0]};
        SZ_WORD: data = raw;
        SZ_TAG:  data = {{(DW-TW){1'b0}},
                         raw[TW-1:0]};
      endcase
    end
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone classic initiator for the load/store stage.
// Ports: req_* in, rsp_* out, wb_* bus, tag-check sideband.
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int WB_DATA_WIDTH     = 32,
  parameter int WB_ADDR_WIDTH     = 32,
  parameter int GRANULE_TAG_WIDTH = 4,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_wdata_i,
  input  logic                     tag_check_en_i,
  output logic                     rsp_valid_o,
  output logic [WB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]               rsp_status_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_ack_i,
  output logic                     check_tags_o,
  input  logic                     tag_mismatch_i,
  output logic                     clear_mismatch_o
);

  localparam logic [7:0] TO_LAST =
    8'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  req_t                     req_q, req_d;
  logic [WB_DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                     cyc_q, cyc_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WB_DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [3:0]               sel_q, sel_d;
  logic                     we_q, we_d;
  logic                     chk_q, chk_d;
  logic                     rvld_q, rvld_d;
  logic [WB_DATA_WIDTH-1:0] rrd_q, rrd_d;
  status_e                  rst_q, rst_d;
  logic [WB_DATA_WIDTH-1:0] aligned;
  logic                     fault;
  logic                     clr;

  wb_lsu_load_align #(
    .DW (WB_DATA_WIDTH),
    .TW (GRANULE_TAG_WIDTH)
  ) u_align (
    .size (req_q.size),
    .uns  (req_q.uns),
    .we   (req_q.we),
    .raw  (rdat_q),
    .data (aligned)
  );

  // Tag granule accesses never fault; only
  // checked RAM accesses honour the flag.
  assign fault = tag_mismatch_i &&
                 req_q.chk &&
                 (req_q.size != SZ_TAG);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdat_d  = rdat_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    chk_d   = chk_q;
    rvld_d  = 1'b0;
    rrd_d   = '0;
    rst_d   = ST_OK;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          req_d.we   = req_we_i;
          req_d.size = size_e'(req_size_i);
          req_d.uns  = req_unsigned_i;
          req_d.chk  = tag_check_en_i;
          if (misaligned(size_e'(req_size_i),
                         req_addr_i[1:0])) begin
            state_d = S_RESP;
            rvld_d  = 1'b1;
            rst_d   = ST_MISALIGN;
          end else begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            addr_d  = req_addr_i;
            wdat_d  = req_wdata_i;
            sel_d   = sel_for(size_e'(req_size_i));
            we_d    = req_we_i;
            chk_d   = tag_check_en_i;
            cnt_d   = '0;
          end
        end
      end
      S_BUS: begin
        if (wb_ack_i) begin
          rdat_d  = wb_data_i;
          cyc_d   = 1'b0;
          state_d = S_CHECK;
        end else if (cnt_q == TO_LAST) begin
          cyc_d   = 1'b0;
          chk_d   = 1'b0;
          state_d = S_RESP;
          rvld_d  = 1'b1;
          rst_d   = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CHECK: begin
        clr     = fault;
        chk_d   = 1'b0;
        state_d = S_RESP;
        rvld_d  = 1'b1;
        rrd_d   = aligned;
        rst_d   = fault ? ST_TAG_FAULT : ST_OK;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdat_q  <= '0;
      cyc_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      chk_q   <= 1'b0;
      rvld_q  <= 1'b0;
      rrd_q   <= '0;
      rst_q   <= ST_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdat_q  <= rdat_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      chk_q   <= chk_d;
      rvld_q  <= rvld_d;
      rrd_q   <= rrd_d;
      rst_q   <= rst_d;
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign rsp_valid_o      = rvld_q;
  assign rsp_rdata_o      = rrd_q;
  assign rsp_status_o     = rst_q;
  assign wb_addr_o        = addr_q;
  assign wb_data_o        = wdat_q;
  assign wb_sel_o         = sel_q;
  assign wb_we_o          = we_q;
  assign wb_cyc_o         = cyc_q;
  assign wb_stb_o         = cyc_q;
  assign check_tags_o     = chk_q;
  assign clear_mismatch_o = clr;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Scoreboard bench for wb_lsu_master.
// Behavioural slave model with ack delay and mismatch flag.
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        tag_chk = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdat = '0;
  logic        wb_ack = 1'b0;
  logic        check_tags;
  logic        mism = 1'b0;
  logic        clr_mism;

  logic        mute = 1'b0;
  logic        force_mism = 1'b0;
  logic        stale_clr = 1'b0;
  int          wait_cnt = 0;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int acc = 0;
  int cyc_hi = 0;
  int clr_cnt = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    int          lat;
    int          cyc;
    int          clr;
  } exp_t;
  exp_t sb[$];

  wb_lsu_master dut (
    .wb_clk_i         (clk),
    .wb_rst_n_i       (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_we_i         (req_we),
    .req_size_i       (req_size),
    .req_unsigned_i   (req_uns),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .tag_check_en_i   (tag_chk),
    .rsp_valid_o      (rsp_valid),
    .rsp_rdata_o      (rsp_rdata),
    .rsp_status_o     (rsp_status),
    .wb_addr_o        (wb_addr),
    .wb_data_o        (wb_wdat),
    .wb_sel_o         (wb_sel),
    .wb_we_o          (wb_we),
    .wb_cyc_o         (wb_cyc),
    .wb_stb_o         (wb_stb),
    .wb_data_i        (wb_rdat),
    .wb_ack_i         (wb_ack),
    .check_tags_o     (check_tags),
    .tag_mismatch_i   (mism),
    .clear_mismatch_o (clr_mism)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave: registered ack one cycle after stb,
  // one extra cycle for byte/half stores (RMW).
  // Mismatch raised in the post-ack cycle.
  always @(posedge clk) begin
    int extra;
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wait_cnt <= 0;
      mism     <= 1'b0;
    end else begin
      wb_ack <= 1'b0;
      extra = (wb_we && (wb_sel == 4'b0001 ||
               wb_sel == 4'b0011)) ? 1 : 0;
      if (wb_cyc && wb_stb && !wb_ack && !mute) begin
        if (wait_cnt == extra) begin
          wb_ack   <= 1'b1;
          wait_cnt <= 0;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
      if (wb_ack && wb_stb && force_mism)
        mism <= 1'b1;
      if (clr_mism || stale_clr)
        mism <= 1'b0;
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (wb_cyc !== wb_stb)
        check("cyc_eq_stb", {31'b0, wb_stb},
              {31'b0, wb_cyc});
      if (wb_cyc) cyc_hi++;
      if (clr_mism) clr_cnt++;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rdata", rsp_rdata, e.d);
          check("status", {30'b0, rsp_status},
                {30'b0, e.s});
          check("latency", cyc_n - acc + 1, e.lat);
          check("cyc_cycles", cyc_hi, e.cyc);
          check("clr_pulses", clr_cnt, e.clr);
        end
      end
    end
  end

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !req_ready) &&
           t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000)
      check("drain_timeout", sb.size(), 0);
  endtask

  task automatic issue(
    input logic        we,
    input logic [1:0]  sz,
    input logic        uns,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic        chk,
    input logic [31:0] ed,
    input logic [1:0]  es,
    input int          elat,
    input int          ecyc,
    input int          eclr,
    input logic [3:0]  esel,
    input logic        want_rsp
  );
    int t = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready)
      check("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wd;
    tag_chk   = chk;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc     = cyc_n;
    cyc_hi  = 0;
    clr_cnt = 0;
    if (want_rsp) begin
      e.d = ed; e.s = es; e.lat = elat;
      e.cyc = ecyc; e.clr = eclr;
      sb.push_back(e);
    end
    if (ecyc > 0) begin
      check("cyc_up", {31'b0, wb_cyc}, 32'd1);
      check("sel", {28'b0, wb_sel},
            {28'b0, esel});
      check("we", {31'b0, wb_we}, {31'b0, we});
      check("addr", wb_addr, addr);
      check("wdata", wb_wdat, wd);
      check("chk_tags", {31'b0, check_tags},
            {31'b0, chk});
    end else begin
      check("no_cyc", {31'b0, wb_cyc}, 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_cyc", {31'b0, wb_cyc}, 32'd0);
    check("rst_rsp", {31'b0, rsp_valid}, 32'd0);
    check("rst_clr", {31'b0, clr_mism}, 32'd0);
    check("rst_sel", {28'b0, wb_sel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    wb_rdat = 32'hDEAD_BEEF;
    issue(0, 2, 0, 32'h10, 0, 0,
          32'hDEAD_BEEF, 0, 4, 2, 0, 4'b1111, 1);
    drain();
    wb_rdat = 32'h0000_0080;
    issue(0, 0, 0, 32'h21, 0, 0,
          32'hFFFF_FF80, 0, 4, 2, 0, 4'b0001, 1);
    issue(0, 0, 1, 32'h21, 0, 0,
          32'h0000_0080, 0, 4, 2, 0, 4'b0001, 1);
    drain();
    wb_rdat = 32'h0000_8001;
    issue(0, 1, 0, 32'h2, 0, 0,
          32'hFFFF_8001, 0, 4, 2, 0, 4'b0011, 1);
    issue(0, 1, 1, 32'h2, 0, 0,
          32'h0000_8001, 0, 4, 2, 0, 4'b0011, 1);
    issue(1, 1, 0, 32'h3, 32'h55, 0,
          0, 2, 1, 0, 0, 4'b0000, 1);
    issue(0, 2, 0, 32'h2, 0, 0,
          0, 2, 1, 0, 0, 4'b0000, 1);
    issue(1, 2, 0, 32'h8, 32'h1234_5678, 0,
          0, 0, 4, 2, 0, 4'b1111, 1);
    issue(1, 0, 0, 32'h5, 32'hAB, 0,
          0, 0, 5, 3, 0, 4'b0001, 1);
    drain();
    wb_rdat = 32'hFFFF_FFF7;
    issue(0, 3, 0, 32'h13, 0, 0,
          32'h0000_0007, 0, 4, 2, 0, 4'b0101, 1);
    drain();

    wb_rdat = 32'hCAFE_0001;
    force_mism = 1'b1;
    issue(0, 2, 0, 32'h1400_0040, 0, 1,
          32'hCAFE_0001, 1, 4, 2, 1, 4'b1111, 1);
    issue(0, 2, 0, 32'h1400_0040, 0, 0,
          32'hCAFE_0001, 0, 4, 2, 0, 4'b1111, 1);
    drain();
    wb_rdat = 32'h0000_0003;
    issue(0, 3, 0, 32'h1400_0040, 0, 1,
          32'h0000_0003, 0, 4, 2, 0, 4'b0101, 1);
    drain();
    repeat (3) @(negedge clk);
    check("stale_mism", {31'b0, mism}, 32'd1);
    check("idle_no_clr", {31'b0, clr_mism}, 32'd0);
    force_mism = 1'b0;
    stale_clr = 1'b1;
    @(negedge clk);
    stale_clr = 1'b0;

    mute = 1'b1;
    issue(0, 2, 0, 32'h30, 0, 0,
          0, 3, 256, 255, 0, 4'b1111, 1);
    drain();
    mute = 1'b0;
    wb_rdat = 32'h0BAD_F00D;
    issue(0, 2, 0, 32'h34, 0, 0,
          32'h0BAD_F00D, 0, 4, 2, 0, 4'b1111, 1);
    drain();

    mute = 1'b1;
    issue(0, 2, 0, 32'h40, 0, 0,
          0, 0, 0, 1, 0, 4'b1111, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_bus_cyc", {31'b0, wb_cyc}, 32'd0);
    check("rst_bus_stb", {31'b0, wb_stb}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mute = 1'b0;
    @(posedge clk);
    #1;
    check("rel_ready", {31'b0, req_ready}, 32'd1);
    check("rel_rsp", {31'b0, rsp_valid}, 32'd0);

    wb_rdat = 32'h0000_FF7F;
    issue(0, 0, 0, 32'h44, 0, 0,
          32'h0000_007F, 0, 4, 2, 0, 4'b0001, 1);
    drain();
    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
